// File: rtl/vga_rect_filler_if.sv
// vga_rect_filler_if
// Groups the command handshake and the pixel-write bus of the rectangle fill
// engine.
//   master : the command source and pixel sink. It drives cmd_* and observes
//            the engine outputs.
//   slave  : the fill engine. It observes cmd_* and drives cmd_ready,
//            data_addr, data_in, write_enable, busy and done.
interface vga_rect_filler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x;
  logic [6:0]  cmd_y;
  logic [7:0]  cmd_w;
  logic [6:0]  cmd_h;
  logic [2:0]  cmd_color;
  logic [14:0] data_addr;
  logic [2:0]  data_in;
  logic        write_enable;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, data_addr, data_in, write_enable, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, data_addr, data_in, write_enable, busy, done
  );
endinterface

// File: rtl/vga_rect_filler.sv
// vga_rect_filler
// Accepts one rectangle command at a time and clips it to the FB_W x FB_H
// frame. It then emits one pixel write every two cycles in row-major order:
// write_enable is high for one cycle and low for the next, which gives the
// downstream read-then-write memory port a rising edge for every pixel. When
// the command completes, done pulses for one cycle.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of vga_rect_filler_if. It carries the command
//              handshake (cmd_valid/cmd_ready, cmd_x/y/w/h/color) and the
//              pixel bus (data_addr, data_in, write_enable, busy, done).
//              Every output on this bus is registered.
module vga_rect_filler #(
  parameter int FB_W = 160,
  parameter int FB_H = 120
) (
  input logic              clk,
  input logic              rst,
  vga_rect_filler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    WR    = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  x_lat;
  logic [7:0]  w_lat;
  logic [6:0]  y_lat;
  logic [6:0]  h_lat;
  logic [2:0]  color_lat;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic [14:0] row_base;

  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic [8:0]  x_end;
  logic [7:0]  y_end;
  logic [8:0]  x_next;
  logic [7:0]  y_next;
  logic        empty;
  logic [14:0] setup_base;

  // Clip window and step values, derived from the latched command. The sums
  // are one bit wider than their operands, so an oversize width or height
  // cannot wrap past the frame edge.
  always_comb begin
    x_sum      = {1'b0, x_lat} + {1'b0, w_lat};
    y_sum      = {1'b0, y_lat} + {1'b0, h_lat};
    x_end      = (x_sum > 9'(FB_W)) ? 9'(FB_W) : x_sum;
    y_end      = (y_sum > 8'(FB_H)) ? 8'(FB_H) : y_sum;
    x_next     = {1'b0, cur_x} + 9'd1;
    y_next     = {1'b0, cur_y} + 8'd1;
    empty      = ({1'b0, x_lat} >= 9'(FB_W)) || ({1'b0, y_lat} >= 8'(FB_H)) ||
                 (w_lat == 8'd0) || (h_lat == 7'd0);
    // Constant multiply; synthesis reduces it to the shift-add 128y + 32y.
    setup_base = 15'(y_lat) * 15'(FB_W);
  end

  // Control FSM. Every output is registered and is set on the edge that
  // enters the state where it must be visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      x_lat            <= 8'd0;
      w_lat            <= 8'd0;
      y_lat            <= 7'd0;
      h_lat            <= 7'd0;
      color_lat        <= 3'd0;
      cur_x            <= 8'd0;
      cur_y            <= 7'd0;
      row_base         <= 15'd0;
      bus.cmd_ready    <= 1'b1;
      bus.data_addr    <= 15'd0;
      bus.data_in      <= 3'd0;
      bus.write_enable <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            x_lat         <= bus.cmd_x;
            y_lat         <= bus.cmd_y;
            w_lat         <= bus.cmd_w;
            h_lat         <= bus.cmd_h;
            color_lat     <= bus.cmd_color;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          if (empty) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            cur_x            <= x_lat;
            cur_y            <= y_lat;
            row_base         <= setup_base;
            bus.data_addr    <= setup_base + 15'(x_lat);
            bus.data_in      <= color_lat;
            bus.write_enable <= 1'b1;
            state            <= WR;
          end
        end
        WR: begin
          // Address and colour hold through GAP; only the strobe drops.
          bus.write_enable <= 1'b0;
          state            <= GAP;
        end
        GAP: begin
          if (x_next < x_end) begin
            cur_x            <= x_next[7:0];
            bus.data_addr    <= row_base + 15'(x_next);
            bus.write_enable <= 1'b1;
            state            <= WR;
          end else if (y_next < y_end) begin
            cur_x            <= x_lat;
            cur_y            <= y_next[6:0];
            row_base         <= row_base + 15'(FB_W);
            bus.data_addr    <= row_base + 15'(FB_W) + 15'(x_lat);
            bus.write_enable <= 1'b1;
            state            <= WR;
          end else begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done      <= 1'b0;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          bus.data_addr <= 15'd0;
          bus.data_in   <= 3'd0;
          state         <= IDLE;
        end
        default: begin
          bus.cmd_ready    <= 1'b1;
          bus.data_addr    <= 15'd0;
          bus.data_in      <= 3'd0;
          bus.write_enable <= 1'b0;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end

endmodule
